// File: rtl/branch_predict_resolve_pkg.sv
// branch_predict_resolve_pkg: opcode, funct3 and BHT counter constants shared by the branch unit
package branch_predict_resolve_pkg;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [2:0] FNC_BEQ  = 3'b000;
  localparam logic [2:0] FNC_BNE  = 3'b001;
  localparam logic [2:0] FNC_BLT  = 3'b100;
  localparam logic [2:0] FNC_BGE  = 3'b101;
  localparam logic [2:0] FNC_BLTU = 3'b110;
  localparam logic [2:0] FNC_BGEU = 3'b111;
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;
  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic t);
    return t ? ((c == CNT_ST) ? CNT_ST : c + 2'd1) : ((c == CNT_SNT) ? CNT_SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/branch_predict_resolve_if.sv
// branch_predict_resolve_if: fetch-predict and execute-resolve signals between pipeline and branch unit
interface branch_predict_resolve_if #(parameter int XLEN = 32, parameter int STAT_W = 32);
  logic [XLEN-1:0]   f_pc;
  logic              f_pred_taken;
  logic              x_valid;
  logic [6:0]        x_opcode;
  logic [2:0]        x_funct3;
  logic [XLEN-1:0]   x_pc;
  logic [XLEN-1:0]   x_rs1;
  logic [XLEN-1:0]   x_rs2;
  logic [XLEN-1:0]   x_target;
  logic              x_pred_taken;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              illegal_br;
  logic [STAT_W-1:0] br_count;
  logic [STAT_W-1:0] mispred_count;
  modport master (output f_pc, x_valid, x_opcode, x_funct3, x_pc, x_rs1, x_rs2, x_target, x_pred_taken,
                  input f_pred_taken, redirect_valid, redirect_pc, illegal_br, br_count, mispred_count);
  modport slave  (input f_pc, x_valid, x_opcode, x_funct3, x_pc, x_rs1, x_rs2, x_target, x_pred_taken,
                  output f_pred_taken, redirect_valid, redirect_pc, illegal_br, br_count, mispred_count);
endinterface

// File: rtl/branch_predict_resolve_compare.sv
// branch_compare: combinational branch condition evaluation from funct3 and operands
module branch_compare #(parameter int XLEN = 32) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_taken,
  output logic            o_illegal
);
  logic w_lt;
  logic w_base;
  // funct3[2] selects less-than over equality, funct3[1] unsigned, funct3[0] inverts
  assign w_lt      = i_funct3[1] ? (i_rs1 < i_rs2) : ($signed(i_rs1) < $signed(i_rs2));
  assign w_base    = i_funct3[2] ? w_lt : (i_rs1 == i_rs2);
  assign o_illegal = i_funct3[2:1] == 2'b01;
  assign o_taken   = o_illegal ? 1'b0 : w_base ^ i_funct3[0];
endmodule

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: BHT prediction at fetch, branch/jump resolution and redirect at execute
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int         XLEN         = 32,
  parameter int         BHT_IDX_BITS = 6,
  parameter logic [1:0] CNT_INIT     = CNT_WNT,
  parameter int         STAT_W       = 32
) (
  input logic clk,
  input logic rst_n,
  branch_predict_resolve_if.slave bus
);
  localparam int N = 1 << BHT_IDX_BITS;
  logic [1:0]              r_bht [N];
  logic                    r_redirect_valid;
  logic [XLEN-1:0]         r_redirect_pc;
  logic                    r_illegal;
  logic [STAT_W-1:0]       r_br;
  logic [STAT_W-1:0]       r_mis;
  logic [BHT_IDX_BITS-1:0] w_fidx;
  logic [BHT_IDX_BITS-1:0] w_xidx;
  logic                    w_taken;
  logic                    w_illegal;
  logic                    w_ev;
  logic                    w_br;
  logic                    w_jmp;
  logic                    w_res;
  logic                    w_mis;
  branch_compare #(.XLEN(XLEN)) u_cmp (
    .i_funct3 (bus.x_funct3),
    .i_rs1    (bus.x_rs1),
    .i_rs2    (bus.x_rs2),
    .o_taken  (w_taken),
    .o_illegal(w_illegal)
  );
  assign w_fidx = bus.f_pc[BHT_IDX_BITS+1:2];
  assign w_xidx = bus.x_pc[BHT_IDX_BITS+1:2];
  // the instruction behind a redirect is wrong-path and must not touch state
  assign w_ev  = bus.x_valid & ~r_redirect_valid;
  assign w_br  = w_ev & (bus.x_opcode == OPC_BRANCH);
  assign w_jmp = w_ev & ((bus.x_opcode == OPC_JAL) | (bus.x_opcode == OPC_JALR));
  assign w_res = w_br & ~w_illegal;
  assign w_mis = w_res & (w_taken != bus.x_pred_taken);
  assign bus.f_pred_taken   = r_bht[w_fidx][1];
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.illegal_br     = r_illegal;
  assign bus.br_count       = r_br;
  assign bus.mispred_count  = r_mis;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_bht[i] <= CNT_INIT;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_illegal        <= 1'b0;
      r_br             <= '0;
      r_mis            <= '0;
    end else begin
      r_redirect_valid <= w_mis | w_jmp;
      r_illegal        <= w_br & w_illegal;
      if (w_mis | w_jmp) r_redirect_pc <= (w_jmp | w_taken) ? bus.x_target : bus.x_pc + XLEN'(4);
      if (w_res) r_bht[w_xidx] <= cnt_next(r_bht[w_xidx], w_taken);
      if (w_res && !(&r_br)) r_br <= r_br + STAT_W'(1);
      if (w_mis && !(&r_mis)) r_mis <= r_mis + STAT_W'(1);
    end
  end
endmodule
